// File: rtl/conv_channel_out_replay_pkg.sv
// Shared types, defaults and width helpers for the channel-out replay block.
package conv_channel_out_replay_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2
    } state_t;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Address width that stays legal for a one-entry plane
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? unsigned'($clog2(depth)) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned count);
        return unsigned'($clog2(count)) + 1;
    endfunction

endpackage

// File: rtl/conv_plane_buffer_ram.sv
// Simple dual-port plane buffer: one write port, one synchronous read port (1-cycle latency).
module conv_plane_buffer_ram
    import conv_channel_out_replay_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Read data holds whenever no read is issued, so a stalled output stays stable
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv_channel_out_replay.sv
// Buffers one feature-map plane and replays it CHANNEL_NUM_OUT times with a per-pass channel index.
// Define CONV_CHANNEL_OUT_REPLAY_PINGPONG_EN for two plane banks so the next plane fills during replay.
module conv_channel_out_replay
    import conv_channel_out_replay_pkg::*;
#(
    parameter int unsigned DATA_WIDTH            = DATA_WIDTH_DEF,
    parameter int unsigned IMAGE_SIZE            = 256 * 256,
    parameter int unsigned CHANNEL_NUM_OUT       = 4,
    parameter int unsigned ADDR_WIDTH            = addr_width(IMAGE_SIZE),
    parameter int unsigned CNT_CHANNEL_OUT_WIDTH = cnt_width(CHANNEL_NUM_OUT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             valid_in,
    input  logic [DATA_WIDTH-1:0]            pxl_in,
    output logic                             ready_in,
    input  logic                             ready_out,
    output logic [DATA_WIDTH-1:0]            pxl_out,
    output logic                             valid_out,
    output logic [CNT_CHANNEL_OUT_WIDTH-1:0] channel_idx,
    output logic                             plane_last,
    output logic                             busy
);

    localparam logic [ADDR_WIDTH-1:0]            LAST_PXL = ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [CNT_CHANNEL_OUT_WIDTH-1:0] LAST_CH  = CNT_CHANNEL_OUT_WIDTH'(CHANNEL_NUM_OUT - 1);

    logic [ADDR_WIDTH-1:0]            wr_ptr;
    logic [ADDR_WIDTH-1:0]            rd_ptr;
    logic [CNT_CHANNEL_OUT_WIDTH-1:0] ch_cnt;
    logic                             ready_q;
    logic                             in_xfer;
    logic                             out_xfer;
    logic                             fill_done;
    logic                             pxl_wrap;
    logic                             rd_last;
    logic                             rd_issue;
    logic                             valid_next;

    // Nothing is accepted while reset is being sampled
    assign ready_in   = ready_q & ~reset;
    assign in_xfer    = valid_in & ready_in;
    assign out_xfer   = valid_out & ready_out;
    assign fill_done  = in_xfer && (wr_ptr == LAST_PXL);
    assign pxl_wrap   = (rd_ptr == LAST_PXL);
    assign rd_last    = pxl_wrap && (ch_cnt == LAST_CH);
    assign valid_next = rd_issue | (valid_out & ~out_xfer);

    // Pointers, pass counter, and the tags that travel with the read data
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ch_cnt      <= '0;
            valid_out   <= 1'b0;
            channel_idx <= '0;
            plane_last  <= 1'b0;
        end else begin
            if (in_xfer) begin
                wr_ptr <= fill_done ? '0 : wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rd_ptr      <= pxl_wrap ? '0 : rd_ptr + ADDR_WIDTH'(1);
                channel_idx <= ch_cnt;
                plane_last  <= pxl_wrap;
                if (pxl_wrap) begin
                    ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CNT_CHANNEL_OUT_WIDTH'(1);
                end
            end
            valid_out <= valid_next;
        end
    end

`ifdef CONV_CHANNEL_OUT_REPLAY_PINGPONG_EN

    logic [1:0]            bank_full;
    logic [1:0]            bank_full_next;
    logic                  fill_bank;
    logic                  rd_bank;
    logic                  out_bank;
    logic [DATA_WIDTH-1:0] rd_data [2];

    // A bank is full from its last write until its last read is issued
    always_comb begin
        bank_full_next = bank_full;
        rd_issue       = bank_full[rd_bank] & (~valid_out | ready_out);
        if (fill_done) begin
            bank_full_next[fill_bank] = 1'b1;
        end
        if (rd_issue && rd_last) begin
            bank_full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full <= '0;
            fill_bank <= 1'b0;
            rd_bank   <= 1'b0;
            out_bank  <= 1'b0;
            ready_q   <= 1'b1;
            busy      <= 1'b0;
        end else begin
            bank_full <= bank_full_next;
            if (fill_done) begin
                fill_bank <= ~fill_bank;
            end
            if (rd_issue) begin
                out_bank <= rd_bank;
            end
            if (rd_issue && rd_last) begin
                rd_bank <= ~rd_bank;
            end
            ready_q <= ~bank_full_next[fill_bank ^ fill_done];
            busy    <= (|bank_full_next) | valid_next;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        conv_plane_buffer_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk     (clk),
            .wr_en   (in_xfer && (fill_bank == 1'(b))),
            .wr_addr (wr_ptr),
            .wr_data (pxl_in),
            .rd_en   (rd_issue && (rd_bank == 1'(b))),
            .rd_addr (rd_ptr),
            .rd_data (rd_data[b])
        );
    end

    assign pxl_out = valid_out ? rd_data[out_bank] : '0;

`else

    state_t                state;
    state_t                state_next;
    logic                  reads_done;
    logic [DATA_WIDTH-1:0] rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            reads_done <= 1'b0;
            ready_q    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != REPLAY);
            busy    <= (state_next != IDLE);
            if (state_next == IDLE) begin
                reads_done <= 1'b0;
            end else if (rd_issue && rd_last) begin
                reads_done <= 1'b1;
            end
        end
    end

    // IDLE and FILL share write handling; a one-pixel plane goes straight to REPLAY
    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (in_xfer) begin
                    state_next = fill_done ? REPLAY : FILL;
                end
            end
            REPLAY: begin
                rd_issue = ~reads_done & (~valid_out | ready_out);
                if (reads_done && out_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    conv_plane_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_xfer),
        .wr_addr (wr_ptr),
        .wr_data (pxl_in),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign pxl_out = valid_out ? rd_data : '0;

`endif

endmodule
